thor2024_rf_write_arb: RTL and testbench
========================================

Name: thor2024_rf_write_arb

Overview:
- Write-port scheduler for the 2-write/6-read register file: funnels NREQ writeback requesters onto file ports wr0/wr1 (we0/we1, wa0/wa1, i0/i1).
- Round-robin, up to two grants per cycle, with a same-address conflict guard.
- Registered outputs drive the register file directly; the file's internal 4x-clock sequencing is outside this block.

Parameters:
- NREQ, 4, number of writeback requesters (power of 2, 2..8)
- WID, 52, register data width
- RBIT, 11, msb index of register address (address width RBIT+1)

Ports:
- clk  in  1  core clock (same clk as register file)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scheduler enable; low = no grants
- req_valid  in  NREQ  writeback request per requester
- req_ready  out  NREQ  grant; transfer when valid&ready at posedge
- req_we  in  NREQ*8  byte enables, requester k at [8k+7:8k]
- req_wa  in  NREQ*(RBIT+1)  target address, packed likewise
- req_data  in  NREQ*WID  write data, packed likewise
- wr0, wr1  out  1  register-file write strobes
- we0, we1  out  8  byte enables
- wa0, wa1  out  RBIT+1  write addresses
- i0, i1  out  WID  write data
- init_done  out  1  scheduler in RUN state

Behaviour:
- States: INIT, RUN. Reset -> INIT if THOR_RFWA_INIT_EN is defined, else RUN.
- Reset (async, rst_n low):
  - all port outputs 0; req_ready 0; rr_ptr 0; init counter 0.
  - init_done is 0 if INIT is compiled in, else 1.
  - Reset mid-sweep or mid-grant aborts immediately; no pending state survives.
- req_ready is combinational from req_valid, rr_ptr, req_wa, en and state.
  - Requesters must not make valid depend on ready.
  - Data must be held stable while valid is high and not granted.
- RUN grant selection each cycle, only when en=1:
  - A = first valid index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - B = next valid index after A in the same scan.
  - A is always granted -> port 0.
  - B is granted -> port 1 only if req_wa[B] != req_wa[A] (full RBIT+1-bit compare). Otherwise B waits for a later cycle.
- Latency: a transfer at posedge N drives wr/we/wa/i on the registered ports for exactly cycle N+1. Ports with no grant output wr=0, we=0, wa=0, data 0.
- r0 rule: a granted request whose wa[4:0]==0 is accepted (ready=1) and consumes its slot, but its port is driven with wr=0, we=0.
- we==0 requests: granted normally; wr=1, we=0 passed through.
- rr_ptr update:
  - B granted -> (B+1) mod NREQ.
  - else A granted -> (A+1) mod NREQ.
  - else unchanged.
  - Wraps at NREQ.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- en=0: req_ready=0; next cycle wr0=wr1=0; rr_ptr held.
- Equal-address same cycle is never issued, so file ordering (wr1 over wr0) is never relied on.

Optional Feature:
- Macro THOR_RFWA_INIT_EN.
- Defined: after reset the block starts in INIT and sweeps the whole file with zeros.
  - Per cycle: wr0=wr1=1, we=8'hFF, i=0, wa0=cnt, wa1=cnt+1; cnt steps by 2 from 0.
  - Last pair is wa0=2^(RBIT+1)-2, wa1=2^(RBIT+1)-1.
  - The cycle after that pair is issued: state RUN, init_done=1. Sweep is 2^RBIT cycles (2048 at default).
  - During INIT: req_ready=0 regardless of en.
- Undefined: no counter logic; RUN directly out of reset; init_done=1 from reset.

Decomposition:
- Package thor2024_rfwa_pkg holds:
  - state enum {RFWA_INIT, RFWA_RUN}
  - R0 field mask constant (wa[4:0])
  - NREQ default
  - byte-enable all-ones constant 8'hFF
- One sub-module, thor2024_rr_pick2: combinational, takes valid vector and rr_ptr, returns one-hot A, one-hot B, and found flags.
- Address compare, output registers and FSM stay in the top.

Test Plan:
- Reset, INIT_EN defined, RBIT=11 -> 2048 cycles of dual writes.
  - First cycle: wa0=0, wa1=1.
  - Last cycle: wa0=4094, wa1=4095.
  - init_done rises the following cycle; req_ready=0 throughout.
- RUN, rr_ptr=0, valid=4'b1111, addresses 5/6/7/8 -> cycle 1 grants 0,1, ports show wa0=5, wa1=6; cycle 2 grants 2,3, wa0=7, wa1=8; rr_ptr returns to 0.
- Requesters 1 and 2 both wa=12'h010, rr_ptr=1 -> only 1 granted (port0), port1 idle; next cycle 2 granted on port0.
- Requester 3 wa=12'h020 (r0 field zero), we=8'hFF, sole valid -> ready=1, next cycle wr0=0, we0=0; rr_ptr becomes 0.
- en=0 with valid=4'b1111 for 3 cycles -> ready=0, wr0=wr1=0, rr_ptr unchanged; en=1 resumes from the held pointer.
- Assert rst_n low one cycle after a grant -> outputs immediately 0, rr_ptr 0, INIT restarts when the macro is defined.

Source files
------------

// File: rtl/thor2024_rfwa_pkg.sv
// thor2024_rfwa_pkg
//   Shared types and constants for the register-file write-port scheduler.
//   - rfwa_state_e : scheduler state (INIT sweep / RUN arbitration)
//   - RFWA_R0_MASK : address field that selects r0 (wa[4:0])
//   - RFWA_NREQ_DEF: default number of writeback requesters
//   - RFWA_BE_ALL  : all-bytes write enable
package thor2024_rfwa_pkg;

   typedef enum logic {
      RFWA_INIT = 1'b0,
      RFWA_RUN  = 1'b1
   } rfwa_state_e;

   localparam logic [4:0] RFWA_R0_MASK  = 5'h1F;
   localparam int         RFWA_NREQ_DEF = 4;
   localparam logic [7:0] RFWA_BE_ALL   = 8'hFF;

endpackage

// File: rtl/thor2024_rr_pick2.sv
// thor2024_rr_pick2
//   Combinational round-robin picker: finds the first two valid requesters
//   scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   Ports:
//     valid   in  NREQ  request vector
//     rr_ptr  in  PW    scan start index
//     a_oh    out NREQ  one-hot first valid requester
//     b_oh    out NREQ  one-hot second valid requester
//     a_found out 1     a_oh is non-zero
//     b_found out 1     b_oh is non-zero
module thor2024_rr_pick2 #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] a_oh,
   output logic [NREQ-1:0] b_oh,
   output logic            a_found,
   output logic            b_found
);

   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      a_oh    = '0;
      b_oh    = '0;
      a_found = 1'b0;
      b_found = 1'b0;
      // NREQ is a power of two, so the PW-bit add wraps the scan for free
      for (int i = 0; i < NREQ; i++) begin
         idx = rr_ptr + PW'(i);
         if (valid[idx]) begin
            if (!a_found) begin
               a_oh[idx] = 1'b1;
               a_found   = 1'b1;
            end else if (!b_found) begin
               b_oh[idx] = 1'b1;
               b_found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/thor2024_rf_write_arb.sv
// thor2024_rf_write_arb
//   Funnels NREQ writeback requesters onto the two register-file write ports.
//   Round-robin, up to two grants per cycle; the second grant is suppressed
//   when it targets the same address as the first. Port outputs are
//   registered: a transfer at posedge N shows on wr/we/wa/i during cycle N+1.
//   Optional macro THOR_RFWA_INIT_EN: after reset, sweep the whole file with
//   zeros (two addresses per cycle) before entering RUN.
//   Ports:
//     clk, rst_n         clock, async active-low reset
//     en                 scheduler enable (low = no grants)
//     req_valid/ready    per-requester handshake (ready is combinational)
//     req_we/wa/data     packed per-requester byte enables, address, data
//     wr0/we0/wa0/i0     write port 0 (strobe, byte enables, address, data)
//     wr1/we1/wa1/i1     write port 1
//     init_done          scheduler is in RUN
module thor2024_rf_write_arb
   import thor2024_rfwa_pkg::*;
#(
   parameter int NREQ = RFWA_NREQ_DEF,
   parameter int WID  = 52,
   parameter int RBIT = 11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*8-1:0]        req_we,
   input  logic [NREQ*(RBIT+1)-1:0] req_wa,
   input  logic [NREQ*WID-1:0]      req_data,
   output logic                     wr0,
   output logic                     wr1,
   output logic [7:0]               we0,
   output logic [7:0]               we1,
   output logic [RBIT:0]            wa0,
   output logic [RBIT:0]            wa1,
   output logic [WID-1:0]           i0,
   output logic [WID-1:0]           i1,
   output logic                     init_done
);

   localparam int AW = RBIT + 1;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef THOR_RFWA_INIT_EN
   localparam rfwa_state_e ST_RST = RFWA_INIT;
`else
   localparam rfwa_state_e ST_RST = RFWA_RUN;
`endif

   rfwa_state_e state_q, state_d;
   logic [PW-1:0] rr_q, rr_d;

   logic            wr0_q, wr0_d, wr1_q, wr1_d;
   logic [7:0]      we0_q, we0_d, we1_q, we1_d;
   logic [AW-1:0]   wa0_q, wa0_d, wa1_q, wa1_d;
   logic [WID-1:0]  i0_q, i0_d, i1_q, i1_d;

   logic [NREQ-1:0] a_oh, b_oh;
   logic            a_found, b_found, b_ok;
   logic [PW-1:0]   a_idx, b_idx;
   logic [AW-1:0]   wa_a, wa_b;
   logic [7:0]      we_a, we_b;
   logic [WID-1:0]  dat_a, dat_b;

   thor2024_rr_pick2 #(.NREQ(NREQ), .PW(PW)) u_pick (
      .valid   (req_valid),
      .rr_ptr  (rr_q),
      .a_oh    (a_oh),
      .b_oh    (b_oh),
      .a_found (a_found),
      .b_found (b_found)
   );

   // one-hot to index (vectors are one-hot, so OR-ing indices is exact)
   always_comb begin
      a_idx = '0;
      b_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (a_oh[k]) a_idx = a_idx | PW'(k);
         if (b_oh[k]) b_idx = b_idx | PW'(k);
      end
   end

   assign wa_a  = req_wa[a_idx*AW +: AW];
   assign wa_b  = req_wa[b_idx*AW +: AW];
   assign we_a  = req_we[a_idx*8 +: 8];
   assign we_b  = req_we[b_idx*8 +: 8];
   assign dat_a = req_data[a_idx*WID +: WID];
   assign dat_b = req_data[b_idx*WID +: WID];

   // never issue two writes to the same register in one cycle
   assign b_ok = b_found && (wa_b != wa_a);

`ifdef THOR_RFWA_INIT_EN
   // pair counter; top bit set means the last pair has been issued
   logic [RBIT:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      req_ready = '0;
      wr0_d = 1'b0; we0_d = '0; wa0_d = '0; i0_d = '0;
      wr1_d = 1'b0; we1_d = '0; wa1_d = '0; i1_d = '0;
`ifdef THOR_RFWA_INIT_EN
      cnt_d = cnt_q;
      if (state_q == RFWA_INIT) begin
         if (cnt_q[RBIT]) begin
            state_d = RFWA_RUN;
            cnt_d   = '0;
         end else begin
            wr0_d = 1'b1; we0_d = RFWA_BE_ALL; wa0_d = {cnt_q[RBIT-1:0], 1'b0};
            wr1_d = 1'b1; we1_d = RFWA_BE_ALL; wa1_d = {cnt_q[RBIT-1:0], 1'b1};
            cnt_d = cnt_q + 1'b1;
         end
      end else
`endif
      if (en) begin
         if (a_found) begin
            req_ready = a_oh;
            rr_d      = a_idx + 1'b1;
            // writes to r0 consume the grant but leave the port idle
            if ((wa_a[4:0] & RFWA_R0_MASK) != '0) begin
               wr0_d = 1'b1; we0_d = we_a; wa0_d = wa_a; i0_d = dat_a;
            end
         end
         if (b_ok) begin
            req_ready = req_ready | b_oh;
            rr_d      = b_idx + 1'b1;
            if ((wa_b[4:0] & RFWA_R0_MASK) != '0) begin
               wr1_d = 1'b1; we1_d = we_b; wa1_d = wa_b; i1_d = dat_b;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST;
         rr_q    <= '0;
         wr0_q <= 1'b0; we0_q <= '0; wa0_q <= '0; i0_q <= '0;
         wr1_q <= 1'b0; we1_q <= '0; wa1_q <= '0; i1_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         wr0_q <= wr0_d; we0_q <= we0_d; wa0_q <= wa0_d; i0_q <= i0_d;
         wr1_q <= wr1_d; we1_q <= we1_d; wa1_q <= wa1_d; i1_q <= i1_d;
      end
   end

`ifdef THOR_RFWA_INIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`endif

   assign wr0 = wr0_q; assign we0 = we0_q; assign wa0 = wa0_q; assign i0 = i0_q;
   assign wr1 = wr1_q; assign we1 = we1_q; assign wa1 = wa1_q; assign i1 = i1_q;
   assign init_done = (state_q == RFWA_RUN);

endmodule

// File: tb/tb_thor2024_rf_write_arb.sv
// Scoreboard bench for thor2024_rf_write_arb (NREQ=4, WID=52, RBIT=11).
// The driver pushes the expected port image for the cycle after each
// directed request pattern; a negedge monitor pops and compares.
module tb_thor2024_rf_write_arb;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [3:0]        req_valid;
   logic [3:0]        req_ready;
   logic [3:0][7:0]   wev;
   logic [3:0][11:0]  wav;
   logic [3:0][51:0]  datv;
   logic              wr0, wr1, init_done;
   logic [7:0]        we0, we1;
   logic [11:0]       wa0, wa1;
   logic [51:0]       i0, i1;
   logic [145:0]      ports_act;

   typedef struct {
      int           cyc;
      logic [145:0] ports;
      string        nm;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

`ifdef THOR_RFWA_INIT_EN
   localparam bit INIT_ON = 1'b1;
`else
   localparam bit INIT_ON = 1'b0;
`endif

   thor2024_rf_write_arb #(.NREQ(4), .WID(52), .RBIT(11)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (wev),
      .req_wa    (wav),
      .req_data  (datv),
      .wr0       (wr0),
      .wr1       (wr1),
      .we0       (we0),
      .we1       (we1),
      .wa0       (wa0),
      .wa1       (wa1),
      .i0        (i0),
      .i1        (i1),
      .init_done (init_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign ports_act = {wr0, we0, wa0, i0, wr1, we1, wa1, i1};

   function automatic logic [145:0] pp(input logic w0, input logic [7:0] e0,
                                       input logic [11:0] a0, input logic [51:0] d0,
                                       input logic w1, input logic [7:0] e1,
                                       input logic [11:0] a1, input logic [51:0] d1);
      return {w0, e0, a0, d0, w1, e1, a1, d1};
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // apply en/valid for this cycle, check ready now, expect ports next cycle
   task automatic issue(input logic en_i, input logic [3:0] v, input logic [3:0] rdy,
                        input logic [145:0] exp, input string nm);
      exp_t e;
      en        = en_i;
      req_valid = v;
      #1;
      chk({nm, "_ready"}, 160'(req_ready), 160'(rdy));
      e.cyc   = cyc + 1;
      e.ports = exp;
      e.nm    = nm;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         if (sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_chk++;
            $display("FAIL %s: port image for cycle %0d not seen, now cycle %0d", e.nm, e.cyc, cyc);
         end else if (sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk({e.nm, "_ports"}, 160'(ports_act), 160'(e.ports));
         end
      end
   end

   initial begin
      localparam logic [145:0] IDLE = '0;
      rst_n = 1'b0; en = 1'b0; req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         wev[k]  = 8'hFF;
         wav[k]  = 12'h001;
         datv[k] = 52'hD00000000000 + 52'(k);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ports", 160'(ports_act), 160'(0));
      chk("reset_ready", 160'(req_ready), 160'(0));
      chk("reset_init_done", 160'(init_done), 160'(!INIT_ON));
      rst_n = 1'b1;

`ifdef THOR_RFWA_INIT_EN
      begin
         int errs;
         logic [145:0] exp;
         errs = 0;
         en = 1'b1; req_valid = 4'hF;
         @(posedge clk);
         for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            exp = pp(1'b1, 8'hFF, 12'(2*k), 52'h0, 1'b1, 8'hFF, 12'(2*k+1), 52'h0);
            if (k == 0) chk("init_first", 160'(ports_act), 160'(exp));
            else if (k == 2047) chk("init_last", 160'(ports_act), 160'(exp));
            else if (ports_act !== exp) errs++;
            if (req_ready !== 4'h0 || init_done !== 1'b0) errs++;
         end
         chk("init_sweep_errs", 160'(errs), 160'(0));
         @(negedge clk);
         chk("init_done_rise", 160'(init_done), 160'(1));
         chk("post_init_idle", 160'(ports_act), 160'(0));
         req_valid = '0;
      end
`endif

      // four requesters, two grants per cycle, pointer back at 0
      tick(); wav = {12'd8, 12'd7, 12'd6, 12'd5};
      issue(1'b1, 4'b1111, 4'b0011, pp(1, 8'hFF, 12'd5, datv[0], 1, 8'hFF, 12'd6, datv[1]), "rr_c1");
      tick();
      issue(1'b1, 4'b1111, 4'b1100, pp(1, 8'hFF, 12'd7, datv[2], 1, 8'hFF, 12'd8, datv[3]), "rr_c2");
      // single grant moves pointer to 1
      tick(); wav[0] = 12'd9;
      issue(1'b1, 4'b0001, 4'b0001, pp(1, 8'hFF, 12'd9, datv[0], 0, 0, 0, 0), "single0");
      // same-address conflict: only requester 1, then 2
      tick(); wav[1] = 12'h010; wav[2] = 12'h010;
      issue(1'b1, 4'b0110, 4'b0010, pp(1, 8'hFF, 12'h010, datv[1], 0, 0, 0, 0), "conflict_a");
      tick();
      issue(1'b1, 4'b0100, 4'b0100, pp(1, 8'hFF, 12'h010, datv[2], 0, 0, 0, 0), "conflict_b");
      // r0 write: accepted, port idle, pointer wraps to 0
      tick(); wav[3] = 12'h020;
      issue(1'b1, 4'b1000, 4'b1000, IDLE, "r0_port0");
      // disabled for three cycles
      tick(); wav = {12'd8, 12'd7, 12'd6, 12'd5};
      issue(1'b0, 4'b1111, 4'b0000, IDLE, "en_off1");
      tick(); issue(1'b0, 4'b1111, 4'b0000, IDLE, "en_off2");
      tick(); issue(1'b0, 4'b1111, 4'b0000, IDLE, "en_off3");
      tick();
      issue(1'b1, 4'b1111, 4'b0011, pp(1, 8'hFF, 12'd5, datv[0], 1, 8'hFF, 12'd6, datv[1]), "en_resume");
      // pointer 2: scan 2,3,0,1 finds 2 then 1; we==0 passes through
      tick(); wev[2] = 8'h00;
      issue(1'b1, 4'b0110, 4'b0110, pp(1, 8'h00, 12'd7, datv[2], 1, 8'hFF, 12'd6, datv[1]), "wrap_we0");
      // pointer 2: finds 3 then 0, pointer becomes 1
      tick(); wev[2] = 8'hFF; wav[0] = 12'h0A1;
      issue(1'b1, 4'b1001, 4'b1001, pp(1, 8'hFF, 12'd8, datv[3], 1, 8'hFF, 12'h0A1, datv[0]), "wrap_b0");
      // pointer 1: 1 on port 0, r0 write from 0 on port 1
      tick(); wav[0] = 12'h040;
      issue(1'b1, 4'b0011, 4'b0011, pp(1, 8'hFF, 12'd6, datv[1], 0, 0, 0, 0), "r0_port1");
      tick(); req_valid = '0;
      repeat (3) tick();

      // reset right after a grant: pointer 1 grants 1,2 then reset clears all
      wav[0] = 12'd5;
      en = 1'b1; req_valid = 4'b1111;
      #1;
      chk("prerst_ready", 160'(req_ready), 160'(4'b0110));
      tick();
      req_valid = '0;
      chk("prerst_ports", 160'(ports_act),
          160'(pp(1, 8'hFF, 12'd6, datv[1], 1, 8'hFF, 12'd7, datv[2])));
      rst_n = 1'b0;
      #1;
      chk("midrst_ports", 160'(ports_act), 160'(0));
      chk("midrst_init_done", 160'(init_done), 160'(!INIT_ON));
      tick();
      rst_n = 1'b1;
`ifdef THOR_RFWA_INIT_EN
      begin
         int n;
         @(posedge clk); @(negedge clk);
         chk("reinit_first", 160'(ports_act),
             160'(pp(1, 8'hFF, 12'd0, 52'h0, 1, 8'hFF, 12'd1, 52'h0)));
         n = 0;
         while (!init_done && n < 3000) begin
            @(negedge clk);
            n++;
         end
         chk("reinit_done", 160'(init_done), 160'(1));
      end
`endif
      // pointer restarted at 0 (it was 3 before reset)
      tick(); wav = {12'd8, 12'd7, 12'd6, 12'd5};
      issue(1'b1, 4'b0011, 4'b0011, pp(1, 8'hFF, 12'd5, datv[0], 1, 8'hFF, 12'd6, datv[1]), "post_rst");
      tick(); req_valid = '0;

      for (int n = 0; n < 10 && sb.size() > 0; n++) tick();
      chk("scoreboard_drained", 160'(sb.size()), 160'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
